// File: rtl/mul8_seq_ctrl.sv
// Purpose : sequences one shared 4x4 approximate sub-multiplier over four
//           nibble quadrants (LL, LH, HL, HH) to build a saturated 8x8 product.
// Latency : accept at cycle T -> out_valid at T+5 (T+1 when either operand is 0).
// Backpress: in_ready only in IDLE; result held in DONE until out_ready.
// Ports   : clk/rst (sync, active-high); in_valid/in_ready/in_a/in_b operand
//           handshake; out_valid/out_ready/out_prod/out_ovf result handshake;
//           sub_a/sub_b/sub_sel drive the external sub-multiplier, sub_prod is
//           its same-cycle combinational answer; busy = not IDLE.
module mul8_seq_ctrl #(
  parameter logic [2:0] SEL_LL = 3'd4,
  parameter logic [2:0] SEL_LH = 3'd4,
  parameter logic [2:0] SEL_HL = 3'd2,
  parameter logic [2:0] SEL_HH = 3'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_prod,
  output logic        out_ovf,
  output logic [3:0]  sub_a,
  output logic [3:0]  sub_b,
  output logic [2:0]  sub_sel,
  input  logic [7:0]  sub_prod,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    Q_LL = 3'd1,
    Q_LH = 3'd2,
    Q_HL = 3'd3,
    Q_HH = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [16:0] acc_q, acc_d;
  logic [15:0] prod_q, prod_d;
  logic        ovf_q, ovf_d;

  // Partial product aligned to the current quadrant's weight.
  logic [16:0] pp_shifted;
  logic [16:0] acc_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      acc_q   <= 17'd0;
      prod_q  <= 16'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_sum = acc_q + pp_shifted;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    prod_d     = prod_q;
    ovf_d      = ovf_q;
    sub_a      = 4'd0;
    sub_b      = 4'd0;
    sub_sel    = 3'd0;
    pp_shifted = 17'd0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = in_a;
          b_d   = in_b;
          acc_d = 17'd0;
          if (in_a == 8'd0 || in_b == 8'd0) begin
            // Zero operand: skip all quadrants, result is exactly 0.
            state_d = DONE;
            prod_d  = 16'd0;
            ovf_d   = 1'b0;
          end else begin
            state_d = Q_LL;
          end
        end
      end
      Q_LL: begin
        sub_a      = a_q[3:0];
        sub_b      = b_q[3:0];
        sub_sel    = SEL_LL;
        pp_shifted = {9'd0, sub_prod};
        acc_d      = acc_sum;
        state_d    = Q_LH;
      end
      Q_LH: begin
        sub_a      = a_q[3:0];
        sub_b      = b_q[7:4];
        sub_sel    = SEL_LH;
        pp_shifted = {5'd0, sub_prod, 4'd0};
        acc_d      = acc_sum;
        state_d    = Q_HL;
      end
      Q_HL: begin
        sub_a      = a_q[7:4];
        sub_b      = b_q[3:0];
        sub_sel    = SEL_HL;
        pp_shifted = {5'd0, sub_prod, 4'd0};
        acc_d      = acc_sum;
        state_d    = Q_HH;
      end
      Q_HH: begin
        sub_a      = a_q[7:4];
        sub_b      = b_q[7:4];
        sub_sel    = SEL_HH;
        pp_shifted = {1'b0, sub_prod, 8'd0};
        acc_d      = acc_sum;
        state_d    = DONE;
        // Approximate partials can push the sum past 16 bits; clamp.
        if (acc_sum[16]) begin
          prod_d = 16'hFFFF;
          ovf_d  = 1'b1;
        end else begin
          prod_d = acc_sum[15:0];
          ovf_d  = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_prod  = prod_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
module tb_mul8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;
  logic        out_ovf;
  logic [3:0]  sub_a;
  logic [3:0]  sub_b;
  logic [2:0]  sub_sel;
  logic [7:0]  sub_prod;
  logic        busy;

  // 0 = exact, 1 = always 8'hFF, 2 = variant-dependent approximation
  logic [1:0]  mode;

  int checks   = 0;
  int failures = 0;

  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  mul8_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_ovf   (out_ovf),
    .sub_a     (sub_a),
    .sub_b     (sub_b),
    .sub_sel   (sub_sel),
    .sub_prod  (sub_prod),
    .busy      (busy)
  );

  function automatic logic [7:0] subm(input logic [3:0] x, input logic [3:0] y,
                                      input logic [2:0] sel, input logic [1:0] m);
    int p;
    p = int'(x) * int'(y);
    case (m)
      2'd1:    return 8'hFF;
      2'd2:    return 8'(p) ^ {5'd0, sel};
      default: return 8'(p);
    endcase
  endfunction

  assign sub_prod = subm(sub_a, sub_b, sub_sel, mode);

  // Reference: sum of the four weighted nibble products, then clamp to 16 bits.
  function automatic logic [16:0] ref_result(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] m);
    int sum;
    if (a == 0 || b == 0) return 17'd0;
    sum = int'(subm(a[3:0], b[3:0], 3'd4, m))
        + int'(subm(a[3:0], b[7:4], 3'd4, m)) * 16
        + int'(subm(a[7:4], b[3:0], 3'd2, m)) * 16
        + int'(subm(a[7:4], b[7:4], 3'd2, m)) * 256;
    if (sum > 65535) return {1'b1, 16'hFFFF};
    return {1'b0, 16'(sum)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares each handshaken result with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("sb_prod", {16'd0, out_prod}, {16'd0, e[15:0]});
        chk("sb_ovf", {31'd0, out_ovf}, {31'd0, e[16]});
      end
    end
  end

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                       input int hold, input bit rst_in_hl);
    logic [16:0] e;
    logic [3:0]  ea[4];
    logic [3:0]  eb[4];
    logic [2:0]  es[4];
    ea[0] = a[3:0]; eb[0] = b[3:0]; es[0] = 3'd4;
    ea[1] = a[3:0]; eb[1] = b[7:4]; es[1] = 3'd4;
    ea[2] = a[7:4]; eb[2] = b[3:0]; es[2] = 3'd2;
    ea[3] = a[7:4]; eb[3] = b[7:4]; es[3] = 3'd2;
    e = ref_result(a, b, m);
    mode     = m;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    tick();
    exp_q.push_back(e);
    in_valid  = 1'b0;
    in_a      = 8'($urandom);
    in_b      = 8'($urandom);
    if (a == 0 || b == 0) begin
      out_ready = 1'b0;
      chk("early_valid_t1", {31'd0, out_valid}, 32'd1);
      chk("early_sub_sel", {29'd0, sub_sel}, 32'd0);
    end else begin
      for (int q = 0; q < 4; q++) begin
        out_ready = 1'($urandom);
        chk("quad_sub_a", {28'd0, sub_a}, {28'd0, ea[q]});
        chk("quad_sub_b", {28'd0, sub_b}, {28'd0, eb[q]});
        chk("quad_sub_sel", {29'd0, sub_sel}, {29'd0, es[q]});
        chk("quad_no_valid", {30'd0, busy, out_valid}, 32'd2);
        if (rst_in_hl && q == 2) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          void'(exp_q.pop_back());
          chk("rst_busy", {31'd0, busy}, 32'd0);
          chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
          chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
          chk("rst_out_prod", {15'd0, out_ovf, out_prod}, 32'd0);
          return;
        end
        tick();
      end
      chk("valid_t5", {31'd0, out_valid}, 32'd1);
    end
    out_ready = (hold == 0);
    for (int h = 0; h < hold - 1; h++) begin
      tick();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_prod", {15'd0, out_ovf, out_prod}, {15'd0, e});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_valid", {31'd0, out_valid}, 32'd0);
    chk("post_prod_kept", {15'd0, out_ovf, out_prod}, {15'd0, e});
    out_ready = 1'($urandom);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 8'd0;
    in_b      = 8'd0;
    out_ready = 1'b0;
    mode      = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_state", {15'd0, out_valid, busy, in_ready, out_ovf, 1'b0, sub_sel, sub_a, sub_b},
        {15'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0});
    chk("rst_prod", {16'd0, out_prod}, 32'd0);
    tick();

    do_op(8'hFF, 8'hFF, 2'd0, 0, 1'b0);
    chk("fe01_direct", {16'd0, out_prod}, 32'hFE01);
    do_op(8'h3C, 8'hA5, 2'd0, 1, 1'b0);
    chk("26ac_direct", {16'd0, out_prod}, 32'h26AC);
    do_op(8'h00, 8'h7F, 2'd0, 0, 1'b0);
    do_op(8'h11, 8'h11, 2'd1, 2, 1'b0);
    chk("sat_direct", {15'd0, out_ovf, out_prod}, 32'h1FFFF);
    do_op(8'h5A, 8'hC3, 2'd2, 10, 1'b0);
    do_op(8'h77, 8'h99, 2'd0, 0, 1'b1);
    do_op(8'h12, 8'h34, 2'd0, 0, 1'b0);
    do_op(8'h80, 8'h00, 2'd1, 1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 9) == 0) ra = 8'd0;
      if ($urandom_range(0, 9) == 0) rb = 8'd0;
      do_op(ra, rb, 2'($urandom_range(0, 2)), $urandom_range(0, 3),
            ($urandom_range(0, 11) == 0));
    end

    tick();
    tick();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
